// File: rtl/clock_switch_arbiter.sv
// rtl/clock_switch_arbiter.sv - request/ack arbiter driving a glitch-free clk1/clk2 selector
// Optional SWITCH timeout with sticky err_timeout/err_clr: define CLK_ARB_TIMEOUT_EN.
module clock_switch_arbiter #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_clk1,
  input  logic req_clk2,
  output logic ack_clk1,
  output logic ack_clk2,
  output logic select,
  input  logic sel1_on,
  input  logic sel2_on,
`ifdef CLK_ARB_TIMEOUT_EN
  input  logic err_clr,
  output logic err_timeout,
`endif
  output logic busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;
  localparam logic [1:0] ST_GRANT2 = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

  logic [3:0]       r_sync [SYNC_STAGES];
  logic             w_r1, w_r2, w_s1, w_s2;
  logic             w_ok1, w_ok2, w_sw_done, w_idle_tgt;
  logic [1:0]       r_state, w_next_state;
  logic             r_target, w_next_target;
  logic             r_select, w_next_select;
  logic             r_ack1, r_ack2, w_ack1, w_ack2;
  logic             r_busy;
  logic [CNT_W-1:0] r_hold, w_next_hold;

`ifdef CLK_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_tmo;
  logic             r_err;
  logic             w_tmo_fire;
`endif

  // Requests and selector status share one synchronizer chain: {s2, s1, r2, r1}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {sel2_on, sel1_on, req_clk2, req_clk1};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign {w_s2, w_s1, w_r2, w_r1} = r_sync[SYNC_STAGES-1];
  assign w_ok1      = w_s1 & ~w_s2;
  assign w_ok2      = w_s2 & ~w_s1;
  assign w_sw_done  = r_target ? w_ok2 : w_ok1;
  assign w_idle_tgt = ~w_r1;

`ifdef CLK_ARB_TIMEOUT_EN
  assign w_tmo_fire = (r_state == ST_SWITCH) && !w_sw_done && (r_tmo <= CNT_W'(1));
`endif

  always_comb begin
    w_next_state  = r_state;
    w_next_target = r_target;
    w_next_select = r_select;
    w_next_hold   = (r_hold == '0) ? '0 : r_hold - 1'b1;
    w_ack1        = 1'b0;
    w_ack2        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_r1 || w_r2) begin
          w_next_target = w_idle_tgt;
          if ((w_idle_tgt == r_select) && (w_idle_tgt ? w_ok2 : w_ok1)) begin
            w_next_state = w_idle_tgt ? ST_GRANT2 : ST_GRANT1;
            w_next_hold  = HOLD_LOAD;
          end else begin
            w_next_select = w_idle_tgt;
            w_next_state  = ST_SWITCH;
          end
        end
      end
      ST_SWITCH: begin
        if (w_sw_done) begin
          // A requester that gave up mid-switch gets no grant cycle.
          if (r_target ? w_r2 : w_r1) begin
            w_next_state = r_target ? ST_GRANT2 : ST_GRANT1;
            w_next_hold  = HOLD_LOAD;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
`ifdef CLK_ARB_TIMEOUT_EN
        else if (w_tmo_fire) begin
          w_next_state = ST_IDLE;
        end
`endif
      end
      ST_GRANT1: begin
        w_ack1 = w_r1;
        if (!w_r1) w_next_state = ST_IDLE;
      end
      ST_GRANT2: begin
        if (!w_r2) begin
          w_next_state = ST_IDLE;
        end else if (w_r1 && (r_hold == '0)) begin
          w_next_state  = ST_SWITCH;
          w_next_target = 1'b0;
          w_next_select = 1'b0;
        end else begin
          w_ack2 = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_target <= 1'b0;
      r_select <= 1'b0;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      r_busy   <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_state  <= w_next_state;
      r_target <= w_next_target;
      r_select <= w_next_select;
      r_ack1   <= w_ack1;
      r_ack2   <= w_ack2;
      r_busy   <= (w_next_state == ST_SWITCH);
      r_hold   <= w_next_hold;
    end
  end

`ifdef CLK_ARB_TIMEOUT_EN
  // Reloaded in every non-SWITCH cycle so it is full on SWITCH entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != ST_SWITCH) r_tmo <= TMO_LOAD;
      else if (r_tmo != '0)     r_tmo <= r_tmo - 1'b1;
      if (w_tmo_fire)           r_err <= 1'b1;
      else if (err_clr)         r_err <= 1'b0;
    end
  end

  assign err_timeout = r_err;
`endif

  assign ack_clk1 = r_ack1;
  assign ack_clk2 = r_ack2;
  assign select   = r_select;
  assign busy     = r_busy;

endmodule
